// File: rtl/uart_msg_pkg.sv
// Shared types, constants and helpers for the ROM-message UART transmitter.
// Define UART_PARITY_EN to insert an even-parity bit between data and stop.
package uart_msg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   localparam int unsigned DEFAULT_CLKS_PER_BIT = 1085;
   localparam int unsigned MSG_ROM_DEPTH        = 4;
   localparam int unsigned ROM_IDX_W            = $clog2(MSG_ROM_DEPTH);

   // "HI\r\n", entry 0 is sent first.
   localparam logic [7:0] MSG_ROM [MSG_ROM_DEPTH] = '{8'h48, 8'h49, 8'h0D, 8'h0A};

   function automatic logic [7:0] rom_byte(input int unsigned idx);
      logic [7:0] v;
      v = 8'h00;
      if (idx < MSG_ROM_DEPTH) begin
         v = MSG_ROM[idx[ROM_IDX_W-1:0]];
      end
      return v;
   endfunction

   // Line level driven while the serializer sits in a given state.
   function automatic logic line_level(input tx_state_e  s,
                                       input logic [7:0] d,
                                       input logic [2:0] b);
      logic v;
      v = 1'b1;
      case (s)
         START:   v = 1'b0;
         DATA:    v = d[b];
         PARITY:  v = ^d;
         default: v = 1'b1;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte UART serializer with bit-time divider; back-to-back bytes via i_start at stop end.
// Optional parity state is compiled in with UART_PARITY_EN.
module uart_tx_byte
   import uart_msg_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [7:0] i_byte,
   output logic       o_serial,
   output logic       o_idle,
   output logic       o_done
);

   localparam int unsigned      DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

   tx_state_e        r_state;
   tx_state_e        w_state_d;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] w_div_d;
   logic [2:0]       r_bit;
   logic [2:0]       w_bit_d;
   logic [7:0]       r_data;
   logic [7:0]       w_data_d;
   logic             r_serial;
   logic             w_serial_d;
   logic             w_div_last;
   logic             w_done;

   assign w_div_last = (r_div == DIV_LAST);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state  <= IDLE;
         r_div    <= '0;
         r_bit    <= '0;
         r_data   <= '0;
         r_serial <= 1'b1;
      end else begin
         r_state  <= w_state_d;
         r_div    <= w_div_d;
         r_bit    <= w_bit_d;
         r_data   <= w_data_d;
         r_serial <= w_serial_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_bit_d   = r_bit;
      w_data_d  = r_data;
      w_done    = 1'b0;
      // Every transition happens on the last divider count, so the divider restarts on entry.
      w_div_d   = (w_div_last || (r_state == IDLE)) ? '0 : r_div + DIV_W'(1);

      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_d = START;
               w_data_d  = i_byte;
            end
         end
         START: begin
            if (w_div_last) begin
               w_state_d = DATA;
               w_bit_d   = '0;
            end
         end
         DATA: begin
            if (w_div_last) begin
               if (r_bit == 3'd7) begin
                  w_bit_d   = '0;
`ifdef UART_PARITY_EN
                  w_state_d = PARITY;
`else
                  w_state_d = STOP;
`endif
               end else begin
                  w_bit_d = r_bit + 3'd1;
               end
            end
         end
         PARITY: begin
            if (w_div_last) begin
               w_state_d = STOP;
            end
         end
         STOP: begin
            if (w_div_last) begin
               w_done = 1'b1;
               if (i_start) begin
                  w_state_d = START;
                  w_data_d  = i_byte;
               end else begin
                  w_state_d = IDLE;
               end
            end
         end
         default: begin
            w_state_d = IDLE;
            w_bit_d   = '0;
         end
      endcase

      // Registered line: compute the level of the state being entered.
      w_serial_d = line_level(w_state_d, w_data_d, w_bit_d);
   end

   assign o_serial = r_serial;
   assign o_idle   = (r_state == IDLE);
   assign o_done   = w_done;

endmodule

// File: rtl/uart_msg_tx_top.sv
// Sends the fixed ROM message once per synchronized rising edge of i_serial_start.
// Frame format is 8N1, or 8E1 when UART_PARITY_EN is defined.
module uart_msg_tx_top
   import uart_msg_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int unsigned MSG_LEN      = 4
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_serial_start,
   output logic o_serial
);

   localparam int unsigned      IDX_W    = $clog2(MSG_LEN + 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_prev;
   logic [IDX_W-1:0] r_byte_idx;
   logic [IDX_W-1:0] w_byte_idx_d;
   logic [IDX_W-1:0] w_load_idx;
   logic [7:0]       w_byte;
   logic             w_edge;
   logic             w_trigger;
   logic             w_more;
   logic             w_tx_start;
   logic             w_tx_idle;
   logic             w_tx_done;

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_prev     <= 1'b0;
         r_byte_idx <= '0;
      end else begin
         r_sync1    <= i_serial_start;
         r_sync2    <= r_sync1;
         r_prev     <= r_sync2;
         r_byte_idx <= w_byte_idx_d;
      end
   end

   assign w_edge = r_sync2 & ~r_prev;

   // Edges seen while a message is in flight (including its final stop cycle) are dropped.
   assign w_trigger  = w_edge & w_tx_idle;
   assign w_more     = (r_byte_idx != IDX_LAST);
   assign w_tx_start = w_trigger | (w_tx_done & w_more);
   assign w_load_idx = w_trigger ? '0 : (r_byte_idx + IDX_W'(1));
   assign w_byte     = rom_byte(32'(w_load_idx));

   always_comb begin
      w_byte_idx_d = r_byte_idx;
      if (w_trigger) begin
         w_byte_idx_d = '0;
      end else if (w_tx_done) begin
         w_byte_idx_d = w_more ? (r_byte_idx + IDX_W'(1)) : '0;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx_byte (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_start (w_tx_start),
      .i_byte  (w_byte),
      .o_serial(o_serial),
      .o_idle  (w_tx_idle),
      .o_done  (w_tx_done)
   );

endmodule

// File: tb/tb_uart_msg_tx_top.sv
// Directed self-checking bench for uart_msg_tx_top with CLKS_PER_BIT=8, MSG_LEN=4.
// Honors UART_PARITY_EN for the expected frame layout.
module tb_uart_msg_tx_top;

   localparam int CPB    = 8;
   localparam int NBYTES = 4;
`ifdef UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CLKS = FRAME_BITS * CPB;
   localparam int TOTAL_CLKS = NBYTES * FRAME_CLKS;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic ser;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] exp_msg [NBYTES] = '{8'h48, 8'h49, 8'h0D, 8'h0A};

   always #4 clk = ~clk;

   uart_msg_tx_top #(
      .CLKS_PER_BIT(CPB),
      .MSG_LEN     (NBYTES)
   ) dut (
      .i_clock       (clk),
      .i_reset       (rst_n),
      .i_serial_start(start),
      .o_serial      (ser)
   );

   function automatic logic exp_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Entered at the first negedge showing the start bit; leaves at the next frame's first negedge.
   task automatic recv_byte(input logic [7:0] b, input bit last, input string tag);
      for (int c = 1; c <= FRAME_CLKS; c++) begin
         @(negedge clk);
         if ((c % CPB) == CPB / 2)
            check_bit($sformatf("%s_bit%0d", tag, c / CPB), ser, exp_bit(b, c / CPB));
      end
      check_bit({tag, "_next"}, ser, last ? 1'b1 : 1'b0);
   endtask

   task automatic recv_message(input string tag);
      for (int i = 0; i < NBYTES; i++)
         recv_byte(exp_msg[i], (i == NBYTES - 1), $sformatf("%s_b%0d", tag, i));
   endtask

   task automatic trigger(input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      check_bit({tag, "_lat1"}, ser, 1'b1);
      @(negedge clk);
      check_bit({tag, "_lat2"}, ser, 1'b1);
      @(negedge clk);
      check_bit({tag, "_lat3"}, ser, 1'b0);
   endtask

   task automatic expect_idle(input int n, input string tag);
      int lows;
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (ser !== 1'b1) lows++;
      end
      check_int({tag, "_lowcycles"}, lows, 0);
   endtask

   task automatic lower(input int n);
      start = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;

      // Reset held 50 ns with the trigger toggling.
      repeat (5) begin
         #10 start = ~start;
         check_bit("rst_line", ser, 1'b1);
      end
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      expect_idle(50, "rst_idle");

      // Single trigger: latency and full message.
      trigger("single");
      recv_message("single");
      expect_idle(100, "single_idle");

      // Retrigger after 500 ns low.
      lower(63);
      trigger("again");
      recv_message("again");
      expect_idle(100, "again_idle");

      // Level held ~10 us produces one message only.
      lower(5);
      trigger("held");
      recv_message("held");
      expect_idle(1250 - 3 - TOTAL_CLKS, "held_idle");
      lower(5);

      // Extra edges during frame 2 are ignored.
      trigger("busy");
      fork
         recv_message("busy");
         begin
            repeat (FRAME_CLKS + 20) @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            start = 1'b1;
            repeat (4) @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            start = 1'b1;
         end
      join
      expect_idle(200, "busy_idle");
      lower(5);

      // Edge pulse coinciding with STOP->IDLE is dropped.
      trigger("bnd_ign");
      fork
         recv_message("bnd_ign");
         begin
            repeat (100) @(negedge clk);
            start = 1'b0;
            repeat (TOTAL_CLKS - 3 - 100) @(negedge clk);
            start = 1'b1;
         end
      join
      expect_idle(100, "bnd_ign_idle");
      lower(5);

      // Edge pulse one cycle later lands in IDLE and is accepted.
      trigger("bnd_acc");
      fork
         recv_message("bnd_acc");
         begin
            repeat (100) @(negedge clk);
            start = 1'b0;
            repeat (TOTAL_CLKS - 2 - 100) @(negedge clk);
            start = 1'b1;
         end
      join
      @(negedge clk);
      check_bit("bnd_acc_restart", ser, 1'b0);
      recv_message("bnd_acc2");
      expect_idle(50, "bnd_acc_idle");
      lower(5);

      // Asynchronous reset during DATA of byte 1.
      trigger("mrst");
      recv_byte(exp_msg[0], 1'b0, "mrst_b0");
      repeat (20) @(negedge clk);
      check_bit("mrst_pre", ser, 1'b0);
      #2 rst_n = 1'b0;
      start = 1'b0;
      #1 check_bit("mrst_async", ser, 1'b1);
      repeat (4) @(negedge clk);
      check_bit("mrst_hold", ser, 1'b1);
      rst_n = 1'b1;
      expect_idle(100, "mrst_idle");
      trigger("mrst_new");
      recv_message("mrst_new");
      expect_idle(50, "mrst_new_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
